// File: rtl/mac_pipe_n.sv
// mac_pipe_n: pipelined multiply-accumulate unit.
// Each operand pair and its flags travel through four stages. Operands are
// registered first. Four half-width partial products come next. Their sum
// with a two's complement correction gives the exact 2*WIDTH product. The
// product is then extended and accumulated, and the result goes into a
// registered output stage. A sample captured at edge N shows up with
// out_valid after edge N+4.
module mac_pipe_n #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40,
    parameter int SAT       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic                 in_clr,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic [ACC_WIDTH-1:0] out_acc,
    output logic                 out_ovf
);

    localparam int  H      = WIDTH / 2;
    localparam int  PW     = 2 * WIDTH;
    localparam bit  SAT_EN = (SAT != 0);

    // Clamp value used when an accumulation overflows with saturation enabled.
    // Signed mode clamps toward the sign of the incoming operand. Unsigned
    // mode clamps to all ones.
    function automatic logic [ACC_WIDTH-1:0] sat_value(input logic is_signed,
                                                       input logic negative);
        logic [ACC_WIDTH-1:0] v;
        if (is_signed) begin
            if (negative) begin
                v = {1'b1, {(ACC_WIDTH-1){1'b0}}};
            end else begin
                v = {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end else begin
            v = {ACC_WIDTH{1'b1}};
        end
        return v;
    endfunction

    // ---------------- stage 1 state ----------------
    logic               v1_r;
    logic [WIDTH-1:0]   a1_r;
    logic [WIDTH-1:0]   b1_r;
    logic               sg1_r;
    logic               clr1_r;

    // ---------------- stage 2 state ----------------
    logic               v2_r;
    logic               sg2_r;
    logic               clr2_r;
    logic [WIDTH-1:0]   pp_ll_r;
    logic [WIDTH-1:0]   pp_hl_r;
    logic [WIDTH-1:0]   pp_lh_r;
    logic [WIDTH-1:0]   pp_hh_r;
    logic [WIDTH-1:0]   corr2_r;

    // ---------------- stage 3 state ----------------
    logic               v3_r;
    logic               sg3_r;
    logic               clr3_r;
    logic [PW-1:0]      prod3_r;

    // ---------------- stage 4 state ----------------
    logic               v4_r;
    logic [PW-1:0]      prod4_r;
    logic [ACC_WIDTH-1:0] acc_r;
    logic               ovf_r;

    // ---------------- output registers ----------------
    logic               out_valid_r;
    logic [PW-1:0]      out_prod_r;
    logic [ACC_WIDTH-1:0] out_acc_r;
    logic               out_ovf_r;

    // ---------------- combinational nets ----------------
    logic [WIDTH-1:0]   a_lo_s, a_hi_s, b_lo_s, b_hi_s;
    logic [WIDTH-1:0]   pp_ll_s, pp_hl_s, pp_lh_s, pp_hh_s;
    logic [WIDTH-1:0]   corr_s;
    logic [PW-1:0]      prod_s;
    logic [ACC_WIDTH-1:0] ext_s;
    logic [ACC_WIDTH:0]   sum_s;
    logic               ovf_s;
    logic [ACC_WIDTH-1:0] acc_nxt_s;
    logic               ovf_nxt_s;

    // Stage 1: capture the operands and the per-sample flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r   <= 1'b0;
            a1_r   <= {WIDTH{1'b0}};
            b1_r   <= {WIDTH{1'b0}};
            sg1_r  <= 1'b0;
            clr1_r <= 1'b0;
        end else begin
            v1_r <= in_valid;
            if (in_valid) begin
                a1_r   <= in_a;
                b1_r   <= in_b;
                sg1_r  <= in_signed;
                clr1_r <= in_clr;
            end
        end
    end

    // Split the operands into zero-extended halves and form the partial products.
    // The correction term removes the weight of the operand sign bits. In signed
    // mode the product is ua*ub - 2^W*(a_msb*ub + b_msb*ua) mod 2^(2W).
    always_comb begin
        a_lo_s  = {{(WIDTH-H){1'b0}}, a1_r[H-1:0]};
        a_hi_s  = {{H{1'b0}}, a1_r[WIDTH-1:H]};
        b_lo_s  = {{(WIDTH-H){1'b0}}, b1_r[H-1:0]};
        b_hi_s  = {{H{1'b0}}, b1_r[WIDTH-1:H]};
        pp_ll_s = a_lo_s * b_lo_s;
        pp_hl_s = a_hi_s * b_lo_s;
        pp_lh_s = a_lo_s * b_hi_s;
        pp_hh_s = a_hi_s * b_hi_s;
        corr_s  = {WIDTH{1'b0}};
        if (sg1_r && a1_r[WIDTH-1]) begin
            corr_s = corr_s + b1_r;
        end else begin
            corr_s = corr_s;
        end
        if (sg1_r && b1_r[WIDTH-1]) begin
            corr_s = corr_s + a1_r;
        end else begin
            corr_s = corr_s;
        end
    end

    // Stage 2: register the partial products and the signed correction term.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_r    <= 1'b0;
            sg2_r   <= 1'b0;
            clr2_r  <= 1'b0;
            pp_ll_r <= {WIDTH{1'b0}};
            pp_hl_r <= {WIDTH{1'b0}};
            pp_lh_r <= {WIDTH{1'b0}};
            pp_hh_r <= {WIDTH{1'b0}};
            corr2_r <= {WIDTH{1'b0}};
        end else begin
            v2_r <= v1_r;
            if (v1_r) begin
                sg2_r   <= sg1_r;
                clr2_r  <= clr1_r;
                pp_ll_r <= pp_ll_s;
                pp_hl_r <= pp_hl_s;
                pp_lh_r <= pp_lh_s;
                pp_hh_r <= pp_hh_s;
                corr2_r <= corr_s;
            end
        end
    end

    // Shift-align the partial products, sum them, and subtract the sign correction.
    always_comb begin
        prod_s = {{WIDTH{1'b0}}, pp_ll_r}
               + {{H{1'b0}}, pp_hl_r, {H{1'b0}}}
               + {{H{1'b0}}, pp_lh_r, {H{1'b0}}}
               + {pp_hh_r, {WIDTH{1'b0}}}
               - {corr2_r, {WIDTH{1'b0}}};
    end

    // Stage 3: register the full product.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_r    <= 1'b0;
            sg3_r   <= 1'b0;
            clr3_r  <= 1'b0;
            prod3_r <= {PW{1'b0}};
        end else begin
            v3_r <= v2_r;
            if (v2_r) begin
                sg3_r   <= sg2_r;
                clr3_r  <= clr2_r;
                prod3_r <= prod_s;
            end
        end
    end

    // Extend the product, add it to the accumulator, and detect overflow
    // (signed sign flip, or unsigned carry out).
    always_comb begin
        if (sg3_r) begin
            ext_s = ACC_WIDTH'($signed(prod3_r));
        end else begin
            ext_s = ACC_WIDTH'(prod3_r);
        end
        sum_s = {1'b0, acc_r} + {1'b0, ext_s};
        if (sg3_r) begin
            ovf_s = (acc_r[ACC_WIDTH-1] == ext_s[ACC_WIDTH-1]) &&
                    (sum_s[ACC_WIDTH-1] != acc_r[ACC_WIDTH-1]);
        end else begin
            ovf_s = sum_s[ACC_WIDTH];
        end
        acc_nxt_s = acc_r;
        ovf_nxt_s = ovf_r;
        if (v3_r) begin
            if (clr3_r) begin
                acc_nxt_s = ext_s;
                ovf_nxt_s = 1'b0;
            end else begin
                if (ovf_s && SAT_EN) begin
                    acc_nxt_s = sat_value(sg3_r, ext_s[ACC_WIDTH-1]);
                end else begin
                    acc_nxt_s = sum_s[ACC_WIDTH-1:0];
                end
                ovf_nxt_s = ovf_r | ovf_s;
            end
        end else begin
            acc_nxt_s = acc_r;
            ovf_nxt_s = ovf_r;
        end
    end

    // Stage 4: update the accumulator and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            v4_r    <= 1'b0;
            prod4_r <= {PW{1'b0}};
            acc_r   <= {ACC_WIDTH{1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            v4_r  <= v3_r;
            acc_r <= acc_nxt_s;
            ovf_r <= ovf_nxt_s;
            if (v3_r) begin
                prod4_r <= prod3_r;
            end
        end
    end

    // Output register: pulse out_valid per sample and hold the results between samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_prod_r  <= {PW{1'b0}};
            out_acc_r   <= {ACC_WIDTH{1'b0}};
            out_ovf_r   <= 1'b0;
        end else begin
            out_valid_r <= v4_r;
            if (v4_r) begin
                out_prod_r <= prod4_r;
                out_acc_r  <= acc_r;
                out_ovf_r  <= ovf_r;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_prod  = out_prod_r;
    assign out_acc   = out_acc_r;
    assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_mac_pipe_n.sv
// Testbench for mac_pipe_n.
// It runs three instances: the default parameters, ACC_WIDTH=32 with
// saturation, and ACC_WIDTH=32 with wrap. Each test is a table of vectors
// with hand-computed results, plus hand-written reset sequences.
module tb_mac_pipe_n;

    typedef struct {
        logic        v;
        logic [15:0] a;
        logic [15:0] b;
        logic        sg;
        logic        clr;
        logic [31:0] prod;
        logic [39:0] acc;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_signed;
    logic        in_clr;

    logic        v0, v1, v2;
    logic [31:0] p0, p1, p2;
    logic [39:0] acc0;
    logic [31:0] acc1, acc2;
    logic        o0, o1, o2;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    mac_pipe_n #(.WIDTH(16), .ACC_WIDTH(40), .SAT(0)) d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_signed(in_signed), .in_clr(in_clr),
        .out_valid(v0), .out_prod(p0), .out_acc(acc0), .out_ovf(o0));

    mac_pipe_n #(.WIDTH(16), .ACC_WIDTH(32), .SAT(1)) d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_signed(in_signed), .in_clr(in_clr),
        .out_valid(v1), .out_prod(p1), .out_acc(acc1), .out_ovf(o1));

    mac_pipe_n #(.WIDTH(16), .ACC_WIDTH(32), .SAT(0)) d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_signed(in_signed), .in_clr(in_clr),
        .out_valid(v2), .out_prod(p2), .out_acc(acc2), .out_ovf(o2));

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic [15:0] a, input logic [15:0] b,
                                input logic sg, input logic clr, input logic [31:0] prod,
                                input logic [39:0] acc, input logic ovf);
        vec_t r;
        r.v = v; r.a = a; r.b = b; r.sg = sg; r.clr = clr;
        r.prod = prod; r.acc = acc; r.ovf = ovf;
        return r;
    endfunction

    task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_vec(input int sel, input string tag, input int idx, input vec_t e);
        logic        gv, go;
        logic [31:0] gp;
        logic [39:0] ga;
        case (sel)
            0:       begin gv = v0; gp = p0; ga = acc0;         go = o0; end
            1:       begin gv = v1; gp = p1; ga = {8'h00, acc1}; go = o1; end
            default: begin gv = v2; gp = p2; ga = {8'h00, acc2}; go = o2; end
        endcase
        cmp($sformatf("%s[%0d].valid", tag, idx), {63'd0, gv}, {63'd0, e.v});
        cmp($sformatf("%s[%0d].prod", tag, idx), {32'd0, gp}, {32'd0, e.prod});
        cmp($sformatf("%s[%0d].acc", tag, idx), {24'd0, ga}, {24'd0, e.acc});
        cmp($sformatf("%s[%0d].ovf", tag, idx), {63'd0, go}, {63'd0, e.ovf});
    endtask

    // Drive the vector table one sample per cycle, then check each result four edges later.
    task automatic run_seq(input int sel, input string tag);
        int n;
        n = vecs.size();
        for (int c = 0; c < n + 4; c++) begin
            @(negedge clk);
            if (c < n) begin
                in_valid  = vecs[c].v;
                in_a      = vecs[c].a;
                in_b      = vecs[c].b;
                in_signed = vecs[c].sg;
                in_clr    = vecs[c].clr;
            end else begin
                in_valid = 1'b0; in_clr = 1'b0;
            end
            @(posedge clk);
            #1;
            if (c >= 4) check_vec(sel, tag, c - 4, vecs[c - 4]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        cmp({tag, ".v0"}, {63'd0, v0}, 64'd0);
        cmp({tag, ".v1"}, {63'd0, v1}, 64'd0);
        cmp({tag, ".v2"}, {63'd0, v2}, 64'd0);
        cmp({tag, ".p0"}, {32'd0, p0}, 64'd0);
        cmp({tag, ".p1"}, {32'd0, p1}, 64'd0);
        cmp({tag, ".acc0"}, {24'd0, acc0}, 64'd0);
        cmp({tag, ".acc1"}, {32'd0, acc1}, 64'd0);
        cmp({tag, ".acc2"}, {32'd0, acc2}, 64'd0);
        cmp({tag, ".ovf"}, {61'd0, o0, o1, o2}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = 16'h0000; in_b = 16'h0000;
        in_signed = 1'b0; in_clr = 1'b0;

        // Reset with random valid samples presented; they must be dropped.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_a      = 16'($urandom);
            in_b      = 16'($urandom);
            in_signed = 1'($urandom);
            in_clr    = 1'($urandom);
        end
        @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            cmp($sformatf("post_reset_valid[%0d]", i), {61'd0, v0, v1, v2}, 64'd0);
        end

        // Default instance: unsigned and signed corners, streaming with bubbles.
        vecs.delete();
        vecs.push_back(mk(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 32'hFFFE0001, 40'h00FFFE0001, 1'b0));
        vecs.push_back(mk(1'b1, 16'h8000, 16'h8000, 1'b1, 1'b1, 32'h40000000, 40'h0040000000, 1'b0));
        vecs.push_back(mk(1'b1, 16'hFFFF, 16'h0002, 1'b1, 1'b0, 32'hFFFFFFFE, 40'h003FFFFFFE, 1'b0));
        vecs.push_back(mk(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b1, 32'h00000001, 40'h0000000001, 1'b0));
        vecs.push_back(mk(1'b1, 16'h0002, 16'h0002, 1'b0, 1'b0, 32'h00000004, 40'h0000000005, 1'b0));
        vecs.push_back(mk(1'b0, 16'h0007, 16'h0007, 1'b0, 1'b1, 32'h00000004, 40'h0000000005, 1'b0));
        vecs.push_back(mk(1'b1, 16'h0003, 16'h0003, 1'b0, 1'b0, 32'h00000009, 40'h000000000E, 1'b0));
        vecs.push_back(mk(1'b1, 16'h0004, 16'h0004, 1'b0, 1'b0, 32'h00000010, 40'h000000001E, 1'b0));
        vecs.push_back(mk(1'b1, 16'hFFFD, 16'h0005, 1'b1, 1'b1, 32'hFFFFFFF1, 40'hFFFFFFFFF1, 1'b0));
        vecs.push_back(mk(1'b1, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 32'h3FFF0001, 40'h003FFEFFF2, 1'b0));
        vecs.push_back(mk(1'b1, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 32'hC0008000, 40'hFFFFFF7FF2, 1'b0));
        vecs.push_back(mk(1'b1, 16'h1234, 16'h0010, 1'b0, 1'b1, 32'h00012340, 40'h0000012340, 1'b0));
        run_seq(0, "dflt");

        // ACC_WIDTH=32 with saturation: unsigned clamp, restart, signed clamps.
        vecs.delete();
        vecs.push_back(mk(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 32'hFFFE0001, 40'h00FFFE0001, 1'b0));
        vecs.push_back(mk(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE0001, 40'h00FFFFFFFF, 1'b1));
        vecs.push_back(mk(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, 32'h00000001, 40'h00FFFFFFFF, 1'b1));
        vecs.push_back(mk(1'b1, 16'h0002, 16'h0003, 1'b0, 1'b1, 32'h00000006, 40'h0000000006, 1'b0));
        vecs.push_back(mk(1'b1, 16'h8000, 16'h8000, 1'b1, 1'b1, 32'h40000000, 40'h0040000000, 1'b0));
        vecs.push_back(mk(1'b1, 16'h8000, 16'h8000, 1'b1, 1'b0, 32'h40000000, 40'h007FFFFFFF, 1'b1));
        vecs.push_back(mk(1'b1, 16'h8000, 16'h7FFF, 1'b1, 1'b1, 32'hC0008000, 40'h00C0008000, 1'b0));
        vecs.push_back(mk(1'b1, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 32'hC0008000, 40'h0080010000, 1'b0));
        vecs.push_back(mk(1'b1, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 32'hC0008000, 40'h0080000000, 1'b1));
        run_seq(1, "sat");

        // ACC_WIDTH=32 with wrap: modulo result, sticky overflow across a bubble.
        vecs.delete();
        vecs.push_back(mk(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 32'hFFFE0001, 40'h00FFFE0001, 1'b0));
        vecs.push_back(mk(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE0001, 40'h00FFFC0002, 1'b1));
        vecs.push_back(mk(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 32'hFFFE0001, 40'h00FFFC0002, 1'b1));
        vecs.push_back(mk(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, 32'h00000001, 40'h00FFFC0003, 1'b1));
        vecs.push_back(mk(1'b1, 16'h0002, 16'h0003, 1'b0, 1'b1, 32'h00000006, 40'h0000000006, 1'b0));
        run_seq(2, "wrap");

        // Reset mid-stream: three samples in flight, then rst on the following cycle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = 16'(i + 5); in_b = 16'h0009;
            in_signed = 1'b0; in_clr = (i == 0) ? 1'b1 : 1'b0;
        end
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_clr = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            cmp($sformatf("midrst_valid[%0d]", i), {61'd0, v0, v1, v2}, 64'd0);
            cmp($sformatf("midrst_acc0[%0d]", i), {24'd0, acc0}, 64'd0);
        end

        // First sample after reset without clr accumulates onto zero.
        vecs.delete();
        vecs.push_back(mk(1'b1, 16'h0003, 16'h0007, 1'b0, 1'b0, 32'h00000015, 40'h0000000015, 1'b0));
        vecs.push_back(mk(1'b1, 16'h0002, 16'h0002, 1'b0, 1'b0, 32'h00000004, 40'h0000000019, 1'b0));
        run_seq(0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
